// File: rtl/io_bridge.sv
// io_bridge: decodes CPU byte accesses into RAM or memory-mapped UART/counter I/O,
// buffers TX/RX bytes in FIFOs and throttles the CPU through cpu_rdy_o.

module io_bridge_fifo #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_head,
    output logic          o_empty,
    output logic          o_full,
    output logic [AW:0]   o_count_next
);
    localparam int DEPTH = 1 << AW;
    localparam int CW    = AW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;
    logic [CW-1:0] w_count_next;

    assign o_empty      = (r_count == '0);
    assign o_full       = (r_count == CW'(DEPTH));
    assign w_do_push    = i_push & ~o_full;
    assign w_do_pop     = i_pop & ~o_empty;
    assign w_count_next = r_count + CW'(w_do_push) - CW'(w_do_pop);
    assign o_count_next = w_count_next;
    assign o_head       = o_empty ? '0 : r_mem[r_rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
        end
    end

    // NOTE: storage has no reset; the count gates every read, so stale contents are never observed.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end
endmodule

module io_bridge #(
    parameter int RAM_AW  = 17,
    parameter int FIFO_AW = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [31:0]       cpu_mem_a,
    input  logic [7:0]        cpu_mem_dout,
    input  logic              cpu_mem_wr,
    output logic [7:0]        cpu_mem_din,
    output logic              cpu_rdy_o,
    output logic [RAM_AW-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_we,
    input  logic [7:0]        ram_din,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              prog_done
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;

    logic          w_io_sel;
    logic [15:0]   w_io_off;
    logic          w_acc;
    logic          w_io_wr;
    logic          w_io_rd;
    logic          w_tx_push;
    logic [7:0]    w_tx_push_data;
    logic          w_tx_pop;
    logic [7:0]    w_tx_head;
    logic          w_tx_empty;
    logic [CW-1:0] w_tx_count_next;
    logic          w_rx_push;
    logic          w_rx_pop;
    logic [7:0]    w_rx_head;
    logic          w_rx_full;
    logic [7:0]    w_io_rdata;
    logic          w_unused_addr;
    logic          w_unused_tx_full;
    logic          w_unused_rx_empty;
    logic [CW-1:0] w_unused_rx_count_next;

    logic          r_sel_q;
    logic [7:0]    r_io_rdata;
    logic          r_rdy;
    logic [31:0]   r_counter;
    logic [31:0]   r_snap;
    logic          r_prog_done;

    assign w_io_sel      = (cpu_mem_a[17:16] == 2'b11);
    assign w_io_off      = cpu_mem_a[15:0];
    assign w_unused_addr = ^cpu_mem_a[31:18];

    // Reset forces acc low so nothing leaks out while the bridge is being flushed.
    assign w_acc   = r_rdy & ~rst_in;
    assign w_io_wr = w_acc & w_io_sel & cpu_mem_wr;
    assign w_io_rd = w_acc & w_io_sel & ~cpu_mem_wr;

    assign ram_a    = cpu_mem_a[RAM_AW-1:0];
    assign ram_dout = cpu_mem_dout;
    assign ram_we   = cpu_mem_wr & ~w_io_sel & w_acc;

    assign w_tx_push      = w_io_wr & (((w_io_off == 16'h0000) & (cpu_mem_dout != 8'h00))
                                       | (w_io_off == 16'h0004));
    assign w_tx_push_data = (w_io_off == 16'h0004) ? 8'h00 : cpu_mem_dout;
    assign w_tx_pop       = tx_valid & tx_ready;

    assign w_rx_push = rx_valid & rx_ready;
    assign w_rx_pop  = w_io_rd & (w_io_off == 16'h0000);

    io_bridge_fifo #(.AW(FIFO_AW), .DW(8)) u_tx_fifo (
        .i_clk        (clk_in),
        .i_rst        (rst_in),
        .i_push       (w_tx_push),
        .i_push_data  (w_tx_push_data),
        .i_pop        (w_tx_pop),
        .o_head       (w_tx_head),
        .o_empty      (w_tx_empty),
        .o_full       (w_unused_tx_full),
        .o_count_next (w_tx_count_next)
    );

    io_bridge_fifo #(.AW(FIFO_AW), .DW(8)) u_rx_fifo (
        .i_clk        (clk_in),
        .i_rst        (rst_in),
        .i_push       (w_rx_push),
        .i_push_data  (rx_data),
        .i_pop        (w_rx_pop),
        .o_head       (w_rx_head),
        .o_empty      (w_unused_rx_empty),
        .o_full       (w_rx_full),
        .o_count_next (w_unused_rx_count_next)
    );

    assign tx_data  = w_tx_head;
    assign tx_valid = ~w_tx_empty;
    assign rx_ready = ~w_rx_full;

    // NOTE: default assignment first keeps this always_comb free of inferred latches.
    always_comb begin
        w_io_rdata = 8'h00;
        if (!cpu_mem_wr) begin
            case (w_io_off)
                16'h0000: w_io_rdata = w_rx_head;
                16'h0004: w_io_rdata = r_counter[7:0];
                16'h0005: w_io_rdata = r_snap[15:8];
                16'h0006: w_io_rdata = r_snap[23:16];
                16'h0007: w_io_rdata = r_snap[31:24];
                default:  w_io_rdata = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_sel_q     <= 1'b1;
            r_io_rdata  <= 8'h00;
            r_rdy       <= 1'b1;
            r_counter   <= 32'd0;
            r_snap      <= 32'd0;
            r_prog_done <= 1'b0;
        end else begin
            r_sel_q    <= w_io_sel;
            r_io_rdata <= w_io_rdata;
            // One push per cycle at most, so a write landing as rdy falls still fits.
            r_rdy      <= (w_tx_count_next < CW'(DEPTH - 1));
            r_counter  <= r_counter + 32'd1;
            if (w_io_rd && (w_io_off == 16'h0004)) begin
                r_snap <= r_counter;
            end
            if (w_io_wr && (w_io_off == 16'h0004)) begin
                r_prog_done <= 1'b1;
            end
        end
    end

    assign cpu_mem_din = r_sel_q ? r_io_rdata : ram_din;
    assign cpu_rdy_o   = r_rdy;
    assign prog_done   = r_prog_done;
endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a queue-based reference model.

module tb_io_bridge;
    localparam int RAM_AW = 17;
    localparam int DEPTH  = 16;
    localparam logic [31:0] IDLE_A = 32'h0000_0100;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [31:0]       cpu_mem_a;
    logic [7:0]        cpu_mem_dout;
    logic              cpu_mem_wr;
    logic [7:0]        cpu_mem_din;
    logic              cpu_rdy_o;
    logic [RAM_AW-1:0] ram_a;
    logic [7:0]        ram_dout;
    logic              ram_we;
    logic [7:0]        ram_din;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              prog_done;

    always #5 clk_in = ~clk_in;

    io_bridge #(.RAM_AW(RAM_AW), .FIFO_AW(4)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .cpu_mem_a    (cpu_mem_a),
        .cpu_mem_dout (cpu_mem_dout),
        .cpu_mem_wr   (cpu_mem_wr),
        .cpu_mem_din  (cpu_mem_din),
        .cpu_rdy_o    (cpu_rdy_o),
        .ram_a        (ram_a),
        .ram_dout     (ram_dout),
        .ram_we       (ram_we),
        .ram_din      (ram_din),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .prog_done    (prog_done)
    );

    // Environment RAM: synchronous, read data one cycle after the address.
    logic [7:0] bram [0:(1<<RAM_AW)-1];
    always @(posedge clk_in) begin
        if (ram_we) bram[ram_a] <= ram_dout;
        ram_din <= bram[ram_a];
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0]  m_ram    [0:(1<<RAM_AW)-1];
    bit          m_ram_wr [0:(1<<RAM_AW)-1];
    logic [7:0]  m_tx_q [$];
    logic [7:0]  m_rx_q [$];
    logic [31:0] m_cnt;
    logic [31:0] m_snap;
    bit          m_prog;
    bit          m_rdy;
    logic [7:0]  m_din;
    bit          m_din_known;

    logic [7:0]  s_din, s_txd;
    logic        s_rdy, s_txv, s_rxr, s_prog, s_we;
    logic [7:0]  dut_tx_log [$];

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
        logic        wr;
        logic        txr;
        logic        rxv;
        logic [7:0]  rxd;
        logic [7:0]  e_din;
        logic        e_we;
        logic        e_txv;
        logic [7:0]  e_txd;
        logic        e_prog;
        logic [4:0]  care;   // {prog, txd, txv, we, din}
    } vec_t;

    vec_t tab [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tx_q.delete();
        m_rx_q.delete();
        m_cnt       = 32'd0;
        m_snap      = 32'd0;
        m_prog      = 1'b0;
        m_rdy       = 1'b1;
        m_din       = 8'h00;
        m_din_known = 1'b1;
    endtask

    // Called at a negedge; holds reset across one rising edge.
    task automatic do_reset();
        rst_in     = 1'b1;
        cpu_mem_wr = 1'b0;
        rx_valid   = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();
    endtask

    // One bus cycle: drive at negedge, compare, advance model on the rising edge.
    task automatic step(input logic [31:0] a, input logic [7:0] d, input logic wr,
                        input logic txr, input logic rxv, input logic [7:0] rxd);
        logic        io;
        logic [15:0] off;
        bit          acc;
        cpu_mem_a    = a;
        cpu_mem_dout = d;
        cpu_mem_wr   = wr;
        tx_ready     = txr;
        rx_valid     = rxv;
        rx_data      = rxd;
        #1;
        s_din  = cpu_mem_din;
        s_rdy  = cpu_rdy_o;
        s_txv  = tx_valid;
        s_txd  = tx_data;
        s_rxr  = rx_ready;
        s_prog = prog_done;
        s_we   = ram_we;
        io  = (a[17:16] == 2'b11);
        off = a[15:0];
        acc = m_rdy;
        if (m_din_known) check("cpu_mem_din", 32'(s_din), 32'(m_din));
        check("cpu_rdy_o", 32'(s_rdy), 32'(m_rdy));
        check("tx_valid", 32'(s_txv), 32'(m_tx_q.size() != 0));
        if (m_tx_q.size() != 0) check("tx_data", 32'(s_txd), 32'(m_tx_q[0]));
        check("rx_ready", 32'(s_rxr), 32'(m_rx_q.size() != DEPTH));
        check("prog_done", 32'(s_prog), 32'(m_prog));
        check("ram_we", 32'(s_we), 32'(wr & ~io & acc));
        check("ram_a", 32'(ram_a), 32'(a[16:0]));
        if (s_txv && txr) dut_tx_log.push_back(s_txd);
        @(posedge clk_in);
        begin
            bit rx_take;
            rx_take = rxv && (m_rx_q.size() != DEPTH);
            if (m_tx_q.size() != 0 && txr) void'(m_tx_q.pop_front());
            m_din_known = acc && !wr;
            m_din       = 8'h00;
            if (acc && !wr) begin
                if (!io) begin
                    m_din_known = m_ram_wr[a[16:0]];
                    m_din       = m_ram[a[16:0]];
                end else if (off == 16'h0000) begin
                    if (m_rx_q.size() != 0) m_din = m_rx_q.pop_front();
                end else if (off == 16'h0004) begin
                    m_din  = m_cnt[7:0];
                    m_snap = m_cnt;
                end else if (off == 16'h0005) m_din = m_snap[15:8];
                else if (off == 16'h0006) m_din = m_snap[23:16];
                else if (off == 16'h0007) m_din = m_snap[31:24];
            end
            if (acc && wr) begin
                if (!io) begin
                    m_ram[a[16:0]]    = d;
                    m_ram_wr[a[16:0]] = 1'b1;
                end else if (off == 16'h0000 && d != 8'h00) begin
                    m_tx_q.push_back(d);
                end else if (off == 16'h0004) begin
                    m_tx_q.push_back(8'h00);
                    m_prog = 1'b1;
                end
            end
            if (rx_take) m_rx_q.push_back(rxd);
            m_rdy = (m_tx_q.size() < DEPTH - 1);
            m_cnt = m_cnt + 32'd1;
        end
        @(negedge clk_in);
    endtask

    initial begin
        tab[0]  = '{32'h0000_0010, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 5'b10111};
        tab[1]  = '{32'h0000_0010, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 5'b00110};
        tab[2]  = '{32'h0003_0001, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 5'b00011};
        tab[3]  = '{32'h0003_0000, 8'h48, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 5'b00111};
        tab[4]  = '{32'h0003_0000, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h48, 1'b0, 5'b01110};
        tab[5]  = '{32'h0000_0010, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 5'b00100};
        tab[6]  = '{32'h0000_0010, 8'h00, 1'b0, 1'b1, 1'b1, 8'h31, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 5'b00100};
        tab[7]  = '{32'h0003_0000, 8'h00, 1'b0, 1'b1, 1'b1, 8'h32, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 5'b00001};
        tab[8]  = '{32'h0003_0000, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h31, 1'b0, 1'b0, 8'h00, 1'b0, 5'b00001};
        tab[9]  = '{32'h0003_0000, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h32, 1'b0, 1'b0, 8'h00, 1'b0, 5'b00001};
        tab[10] = '{32'h0000_0010, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 5'b00001};
        tab[11] = '{32'h0003_0004, 8'h55, 1'b1, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 5'b10001};
        tab[12] = '{32'h0000_0010, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 5'b11100};
        tab[13] = '{32'h0000_0010, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 5'b10100};

        rst_in       = 1'b1;
        cpu_mem_a    = IDLE_A;
        cpu_mem_dout = 8'h00;
        cpu_mem_wr   = 1'b0;
        tx_ready     = 1'b0;
        rx_valid     = 1'b0;
        rx_data      = 8'h00;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();

        // Directed vector table: RAM round-trip, TX path, RX reads, stop write
        for (int i = 0; i < 14; i++) begin
            step(tab[i].a, tab[i].d, tab[i].wr, tab[i].txr, tab[i].rxv, tab[i].rxd);
            if (tab[i].care[0]) check($sformatf("tab%0d din", i), 32'(s_din), 32'(tab[i].e_din));
            if (tab[i].care[1]) check($sformatf("tab%0d ram_we", i), 32'(s_we), 32'(tab[i].e_we));
            if (tab[i].care[2]) check($sformatf("tab%0d tx_valid", i), 32'(s_txv), 32'(tab[i].e_txv));
            if (tab[i].care[3]) check($sformatf("tab%0d tx_data", i), 32'(s_txd), 32'(tab[i].e_txd));
            if (tab[i].care[4]) check($sformatf("tab%0d prog_done", i), 32'(s_prog), 32'(tab[i].e_prog));
        end

        // Counter snapshot across the 0xFF -> 0x100 rollover
        do_reset();
        for (int i = 0; i < 400 && m_cnt != 32'h0000_00FF; i++) step(IDLE_A, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        step(32'h0003_0004, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        step(32'h0003_0005, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        check("cnt byte0", 32'(s_din), 32'h0000_00FF);
        step(32'h0003_0006, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        check("cnt byte1", 32'(s_din), 32'h0);
        step(32'h0003_0007, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        check("cnt byte2", 32'(s_din), 32'h0);
        step(IDLE_A, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        check("cnt byte3", 32'(s_din), 32'h0);

        // Back-pressure: fill with tx_ready low, then drain
        do_reset();
        begin
            int  pushes;
            bit  extra;
            bit  drained;
            pushes  = 0;
            extra   = 1'b0;
            drained = 1'b0;
            dut_tx_log.delete();
            for (int i = 0; i < 40; i++) begin
                step(32'h0003_0000, 8'h41, 1'b1, 1'b0, 1'b0, 8'h00);
                if (s_rdy) pushes++;
                else break;
            end
            check("bp pushes before rdy low", 32'(pushes), 32'd15);
            for (int i = 0; i < 3; i++) step(32'h0003_0000, 8'h41, 1'b1, 1'b0, 1'b0, 8'h00);
            check("bp rdy held low", 32'(s_rdy), 32'd0);
            for (int i = 0; i < 60 && !drained; i++) begin
                if (!extra) begin
                    step(32'h0003_0000, 8'h41, 1'b1, 1'b1, 1'b0, 8'h00);
                    if (s_rdy) extra = 1'b1;
                end else begin
                    step(IDLE_A, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
                    if (!s_txv) drained = 1'b1;
                end
            end
            check("bp drain finished", 32'(drained), 32'd1);
            check("bp drained count", 32'(dut_tx_log.size()), 32'd16);
            foreach (dut_tx_log[k]) check($sformatf("bp byte%0d", k), 32'(dut_tx_log[k]), 32'h41);
            check("bp rdy restored", 32'(s_rdy), 32'd1);
        end

        // RX fill to 16 with no reads, 17th dropped, then read back in order
        do_reset();
        for (int i = 0; i < 17; i++) begin
            step(IDLE_A, 8'h00, 1'b0, 1'b1, 1'b1, 8'(8'h60 + i));
            if (i == 15) check("rx_ready before 16th", 32'(s_rxr), 32'd1);
            if (i == 16) check("rx_ready after 16", 32'(s_rxr), 32'd0);
        end
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) step(32'h0003_0000, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
            else step(32'h0003_0000, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
            if (i > 0) check($sformatf("rx byte%0d", i - 1), 32'(s_din), 32'(8'h60 + i - 1));
        end
        step(IDLE_A, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        check("rx empty read", 32'(s_din), 32'h0);

        // Stop write, then asynchronous reset in the middle of a burst
        do_reset();
        step(32'h0003_0004, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) step(32'h0003_0000, 8'h41, 1'b1, 1'b0, 1'b0, 8'h00);
        check("stop prog_done", 32'(s_prog), 32'd1);
        check("stop rdy low", 32'(s_rdy), 32'd0);
        cpu_mem_a    = 32'h0000_0020;
        cpu_mem_dout = 8'h77;
        cpu_mem_wr   = 1'b1;
        #2 rst_in = 1'b1;
        #1;
        check("rst prog_done", 32'(prog_done), 32'd0);
        check("rst tx_valid", 32'(tx_valid), 32'd0);
        check("rst tx_data", 32'(tx_data), 32'h0);
        check("rst cpu_rdy_o", 32'(cpu_rdy_o), 32'd1);
        check("rst ram_we", 32'(ram_we), 32'd0);
        check("rst cpu_mem_din", 32'(cpu_mem_din), 32'h0);
        check("rst rx_ready", 32'(rx_ready), 32'd1);
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] hi;
            logic [17:0] base;
            logic [31:0] a;
            int          sel;
            bit          txr;
            sel = int'($urandom_range(0, 9));
            hi  = $urandom();
            case (sel)
                0, 1, 2: base = 18'($urandom_range(0, 63));
                3, 4, 5: base = 18'h30000;
                6, 7:    base = 18'h30004 + 18'($urandom_range(0, 3));
                8:       base = ($urandom_range(0, 1) != 0) ? 18'h30001 : 18'h30008;
                default: base = hi[17:0];
            endcase
            a   = ($urandom_range(0, 3) == 0) ? {hi[31:18], base} : {14'h0, base};
            txr = (i < 1000) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            step(a, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom()),
                 1'($urandom_range(0, 1)), txr, 1'($urandom_range(0, 1)), 8'($urandom()));
            if ($urandom_range(0, 599) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
